pep_mmacc_boram_rd_arb: RTL

- Read-request arbiter and response router for the mmacc body RAM read interface (boram_rd_* / boram_sxt_data_*).
- Shares the single body-RAM read port between REQ_NB sample-extract requesters using round-robin.
- Tracks the owner of each outstanding read in a tag FIFO. Returns each in-order body value to the requester that issued it.

---
 rtl/pep_mmacc_boram_rd_arb.sv | 108 ++++++++++
 1 files changed

// File: rtl/pep_mmacc_boram_rd_arb.sv
// pep_mmacc_boram_rd_arb: round-robin body-RAM read arbiter with in-order response routing.
// Optional stall counter under PEP_MMACC_BORAM_ARB_PERF_EN.
module pep_mmacc_boram_rd_arb #(
   parameter int REQ_NB    = 2,
   parameter int PID_W     = 5,
   parameter int DATA_W    = 11,
   parameter int TAG_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    s_rst,
   input  logic [REQ_NB*PID_W-1:0] req_pid,
   input  logic [REQ_NB-1:0]       req_parity,
   input  logic [REQ_NB-1:0]       req_vld,
   output logic [REQ_NB-1:0]       req_rdy,
   output logic [PID_W-1:0]        boram_rd_pid,
   output logic                    boram_rd_parity,
   output logic                    boram_rd_vld,
   input  logic                    boram_rd_rdy,
   input  logic [DATA_W-1:0]       boram_sxt_data,
   input  logic                    boram_sxt_data_vld,
   output logic                    boram_sxt_data_rdy,
   output logic [DATA_W-1:0]       rsp_data,
   output logic [REQ_NB-1:0]       rsp_vld,
   input  logic [REQ_NB-1:0]       rsp_rdy,
   output logic                    arb_idle,
   output logic [31:0]             perf_stall_cnt
);
   localparam int IDX_W = $clog2(REQ_NB);
   localparam int CNT_W = $clog2(TAG_DEPTH + 1);
   localparam int PTR_W = $clog2(TAG_DEPTH);

   logic [IDX_W-1:0] r_gptr, w_winner, w_head;
   logic [IDX_W-1:0] r_tag [TAG_DEPTH];
   logic [PTR_W-1:0] r_wptr, r_rptr;
   logic [CNT_W-1:0] r_cnt;
   logic [PID_W-1:0] r_rd_pid;
   logic             r_rd_vld, r_rd_parity;
   logic             w_found, w_accept, w_pop, w_has_tag;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < REQ_NB; k++) begin
         if (!w_found && req_vld[(int'(r_gptr) + k) % REQ_NB]) begin
            w_found  = 1'b1;
            w_winner = IDX_W'((int'(r_gptr) + k) % REQ_NB);
         end
      end
   end

   // cnt is compared registered: a pop in this cycle does not free a slot until next cycle
   assign w_has_tag          = r_cnt != '0;
   assign w_accept           = w_found && (r_cnt < CNT_W'(TAG_DEPTH)) && (!r_rd_vld || boram_rd_rdy);
   assign req_rdy            = w_accept ? REQ_NB'(1) << w_winner : '0;
   assign w_head             = r_tag[r_rptr];
   assign rsp_vld            = (boram_sxt_data_vld && w_has_tag) ? REQ_NB'(1) << w_head : '0;
   assign boram_sxt_data_rdy = w_has_tag && rsp_rdy[w_head];
   assign w_pop              = boram_sxt_data_vld && boram_sxt_data_rdy;
   assign rsp_data           = boram_sxt_data;
   assign arb_idle           = !w_has_tag && !r_rd_vld;
   assign boram_rd_vld       = r_rd_vld;
   assign boram_rd_pid       = r_rd_pid;
   assign boram_rd_parity    = r_rd_parity;

   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_gptr   <= '0;
         r_cnt    <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_rd_vld <= 1'b0;
      end else begin
         if (w_accept) begin
            r_gptr <= (w_winner == IDX_W'(REQ_NB - 1)) ? '0 : w_winner + 1'b1;
            r_wptr <= f_inc(r_wptr);
         end
         if (w_pop) r_rptr <= f_inc(r_rptr);
         r_cnt    <= r_cnt + CNT_W'(w_accept) - CNT_W'(w_pop);
         r_rd_vld <= w_accept || (r_rd_vld && !boram_rd_rdy);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tag[r_wptr] <= w_winner;
         r_rd_pid      <= req_pid[w_winner*PID_W +: PID_W];
         r_rd_parity   <= req_parity[w_winner];
      end
   end

`ifdef PEP_MMACC_BORAM_ARB_PERF_EN
   logic [31:0] r_stall;
   always_ff @(posedge clk) begin
      if (s_rst) r_stall <= '0;
      else if (|req_vld && !w_accept && r_stall != '1) r_stall <= r_stall + 1'b1;
   end
   assign perf_stall_cnt = r_stall;
`else
   assign perf_stall_cnt = '0;
`endif

   a_rsp_tag : assert property (@(posedge clk) disable iff (s_rst) !(boram_sxt_data_vld && !w_has_tag))
      else $fatal(1, "response without tag");
endmodule
